// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps every a/b operand pair into a 2-input AND gate,
//   waits SETTLE cycles, then checks dut_out against a & b and counts mismatches.
// Latency: 2^(2*WIDTH) * (SETTLE+1) cycles from the start-accepting edge to done.
// Backpressure: none; start is a single-cycle request and is ignored while busy.
//
// Ports:
//   clk, rst_n (synchronous, active-low)   - single clock domain
//   start                                  - begin a sweep from IDLE or DONE
//   dut_out [WIDTH]                        - response from the gate under test
//   a_out, b_out [WIDTH]                   - operands driven to the gate
//   busy, done, pass                       - sweep status (pass = done & no errors)
//   err_count [2*WIDTH+1]                  - mismatching vectors in the last sweep
//
// Optional build macro GATE_CHECK_STOP_ON_ERR_EN: end the sweep at the first
// mismatch and hold the failing vector on a_out/b_out.

module gate_vector_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dut_out,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  // Last counter value seen in SETTLE before moving to CHECK.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] vec_q,   vec_d;
  logic [7:0]    cnt_q,   cnt_d;
  logic [EW-1:0] err_q,   err_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          mismatch;
  logic          vec_last;

  always_comb begin
    // Operand A is the upper half of the sweep vector, B the lower half.
    mismatch = (dut_out != (vec_q[VW-1:WIDTH] & vec_q[WIDTH-1:0]));
    vec_last = &vec_q;

    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        cnt_d = '0;
        if (mismatch) begin
          err_d = err_q + {{(EW-1){1'b0}}, 1'b1};
        end
`ifdef GATE_CHECK_STOP_ON_ERR_EN
        // Stop on the first failure, leaving the failing vector on the outputs.
        if (mismatch || vec_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + {{(VW-1){1'b0}}, 1'b1};
          state_d = S_SETTLE;
        end
`else
        // vec stops at all-ones so a_out/b_out keep the final vector.
        if (vec_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + {{(VW-1){1'b0}}, 1'b1};
          state_d = S_SETTLE;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_out     = vec_q[VW-1:WIDTH];
  assign b_out     = vec_q[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign pass      = done_q && (err_q == '0);

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: two instances (WIDTH=1 and WIDTH=2, SETTLE=2)
// driven by a modelled gate (AND, OR or stuck-at-0) and checked per cycle
// against a reference computed by enumerating the operand space.

module tb_gate_vector_checker;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;

  logic [0:0] dut1, a1, b1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;

  logic [1:0] dut2, a2, b2;
  logic       busy2, done2, pass2;
  logic [4:0] err2;

  int mode = 0;   // 0: AND gate, 1: OR gate, 2: stuck at 0
  int sel  = 1;   // which instance is observed

  int n_vec = 0;
  int n_err = 0;

  int oa, ob, obusy, odone, opass, oerr;

  always #5 clk = ~clk;

  gate_vector_checker #(.WIDTH(1), .SETTLE(S)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dut1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1)
  );

  gate_vector_checker #(.WIDTH(2), .SETTLE(S)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_out(dut2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2)
  );

  function automatic int gate_resp(input int m, input int a, input int b);
    if (m == 0)      return a & b;
    else if (m == 1) return a | b;
    else             return 0;
  endfunction

  always_comb begin
    dut1 = 1'(gate_resp(mode, int'(a1), int'(b1)));
    dut2 = 2'(gate_resp(mode, int'(a2), int'(b2)));
  end

  always_comb begin
    if (sel == 1) begin
      oa = int'(a1); ob = int'(b1); obusy = int'(busy1);
      odone = int'(done1); opass = int'(pass1); oerr = int'(err1);
    end else begin
      oa = int'(a2); ob = int'(b2); obusy = int'(busy2);
      odone = int'(done2); opass = int'(pass2); oerr = int'(err2);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input int w, input logic v);
    if (w == 1) start1 = v;
    else        start2 = v;
  endtask

  // restart_at: cycle to pulse a spurious start (-1 none, -2 random).
  // rst_at: cycle to pulse reset (-1 none).
  task automatic sweep(input int w, input int m, input int restart_at, input int rst_at);
    int n, mask, t_total, err_exp, last, first, mism, v;
    n     = 1 << (2 * w);
    mask  = (1 << w) - 1;
    sel   = w;
    mode  = m;
    mism  = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if ((gate_resp(m, i >> w, i & mask) & mask) != ((i >> w) & (i & mask))) begin
        mism++;
        if (first < 0) first = i;
      end
    end
`ifdef GATE_CHECK_STOP_ON_ERR_EN
    if (first >= 0) begin
      last = first; err_exp = 1;
    end else begin
      last = n - 1; err_exp = 0;
    end
`else
    last    = n - 1;
    err_exp = mism;
`endif
    t_total = (last + 1) * (S + 1);
    if (restart_at == -2) restart_at = $urandom_range(0, t_total - 1);

    @(posedge clk); #1;
    drive_start(w, 1'b1);
    @(posedge clk); #1;
    drive_start(w, 1'b0);

    for (int t = 0; t <= t_total; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      drive_start(w, 1'b0);
      if (t < t_total) begin
        v = t / (S + 1);
        check("busy_run", obusy, 1);
        check("done_run", odone, 0);
        check("a_run", oa, v >> w);
        check("b_run", ob, v & mask);
      end else begin
        check("busy_end", obusy, 0);
        check("done_end", odone, 1);
        check("err_end", oerr, err_exp);
        check("pass_end", opass, (err_exp == 0) ? 1 : 0);
        check("a_end", oa, last >> w);
        check("b_end", ob, last & mask);
      end
      if (t == restart_at) drive_start(w, 1'b1);
      if (t == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_a", oa, 0);
        check("rst_b", ob, 0);
        check("rst_busy", obusy, 0);
        check("rst_done", odone, 0);
        check("rst_pass", opass, 0);
        check("rst_err", oerr, 0);
        @(posedge clk); #1;
        check("rst_idle_busy", obusy, 0);
        check("rst_idle_done", odone, 0);
        return;
      end
    end

    // Result must hold while no new start arrives.
    repeat (2) @(posedge clk);
    #1;
    check("done_hold", odone, 1);
    check("err_hold", oerr, err_exp);
    check("a_hold", oa, last >> w);
    check("b_hold", ob, last & mask);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k <= 2; k++) begin
      sel = k;
      #0;
      #1;
      check("reset_busy", obusy, 0);
      check("reset_done", odone, 0);
      check("reset_pass", opass, 0);
      check("reset_err", oerr, 0);
      check("reset_a", oa, 0);
      check("reset_b", ob, 0);
    end
    rst_n = 1'b1;

    sweep(1, 0, -1, -1);   // good gate
    sweep(1, 1, -1, -1);   // OR gate, restarted from DONE
    sweep(1, 0,  4, -1);   // spurious start mid-sweep
    sweep(1, 0, -1,  5);   // reset mid-sweep
    sweep(1, 0, -1, -1);   // full sweep after reset
    sweep(2, 2, -1, -1);   // stuck-at-0, WIDTH=2
    sweep(2, 1, -1, -1);   // OR gate, WIDTH=2
    sweep(2, 0, -1, -1);   // good gate, WIDTH=2

    for (int r = 0; r < 6; r++) begin
      sweep(int'($urandom_range(1, 2)), int'($urandom_range(0, 2)), -2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
